// File: rtl/huffman_code_gen.sv
// rtl/huffman_code_gen.sv - Huffman code-table generator (depth-first tree walk)
//
// Walks a binary Huffman tree stored in shared memory from root node 0 using
// an explicit stack. Each leaf produces one code-table word {length, code},
// where the code is left-aligned MSB-first.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       begin a run (sampled only when idle)
//   busy        high whenever not idle
//   done        one-cycle pulse at the end of a run
//   error       raised with done on a failed run, held until next start
//   sym_count   leaves written in the current/last run
//   mem_addr    shared read/write address
//   mem_rd      read strobe, one cycle per read
//   mem_wr      write strobe, one cycle per write
//   mem_rdata   child reference returned by memory
//   mem_wdata   write data {len, code}
module huffman_code_gen #(
   parameter int SYM_W     = 8,
   parameter int MAX_LEN   = 16,
   parameter int LEN_W     = 5,
   parameter int ADDR_W    = 10,
   parameter int NODE_BASE = 256,
   parameter int CODE_BASE = 0,
   parameter int MEM_LAT   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [SYM_W:0]            sym_count,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_rd,
   output logic                      mem_wr,
   input  logic [SYM_W:0]            mem_rdata,
   output logic [LEN_W+MAX_LEN-1:0]  mem_wdata
);

   localparam int NUM_SYM = 2**SYM_W;
   localparam int SP_W    = $clog2(MAX_LEN + 1);
   localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT, S_EVAL, S_WRITE, S_ADVANCE, S_DONE, S_ERR
   } state_t;

   state_t               state, next_state;
   logic [SP_W-1:0]      sp;
   logic [SYM_W-1:0]     stk_node [MAX_LEN];
   logic [MAX_LEN-1:0]   stk_br;
   logic [SYM_W:0]       child;
   logic [CNT_W-1:0]     wait_cnt;
   logic                 error_q;
   logic [MAX_LEN-1:0]   code;
   logic [IDX_W-1:0]     top_idx, push_idx;
   logic [SYM_W-1:0]     top_node;
   logic                 top_br;
   logic                 wait_last, at_max, table_full, is_internal;

   assign top_idx     = IDX_W'(sp - 1'b1);
   assign push_idx    = IDX_W'(sp);
   assign top_node    = stk_node[top_idx];
   assign top_br      = stk_br[top_idx];
   assign wait_last   = (wait_cnt == CNT_W'(MEM_LAT - 1));
   assign at_max      = (sp == SP_W'(MAX_LEN));
   assign table_full  = (sym_count == (SYM_W+1)'(NUM_SYM));
   assign is_internal = child[SYM_W];

   // Code bit for depth k comes from the branch taken at stack entry k.
   always_comb begin
      code = '0;
      for (int k = 0; k < MAX_LEN; k++)
         if (SP_W'(k) < sp) code[MAX_LEN-1-k] = stk_br[k];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:    if (start) next_state = S_READ;
         S_READ:    next_state = S_WAIT;
         S_WAIT:    if (wait_last) next_state = S_EVAL;
         S_EVAL:    if (!is_internal) next_state = S_WRITE;
                    else if (at_max)  next_state = S_ERR;
                    else              next_state = S_READ;
         S_WRITE:   next_state = table_full ? S_ERR : S_ADVANCE;
         // Branch 1 done: unwind one level per cycle until an unfinished node.
         S_ADVANCE: if (!top_br)                next_state = S_READ;
                    else if (sp == SP_W'(1))    next_state = S_DONE;
         S_DONE:    next_state = S_IDLE;
         S_ERR:     next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE) || (state == S_ERR);
      error     = error_q || (state == S_ERR);
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_READ: begin
            mem_rd   = 1'b1;
            mem_addr = ADDR_W'(NODE_BASE) + ADDR_W'({top_node, top_br});
         end
         S_WRITE: if (!table_full) begin
            mem_wr    = 1'b1;
            mem_addr  = ADDR_W'(CODE_BASE) + ADDR_W'(child[SYM_W-1:0]);
            mem_wdata = {LEN_W'(sp), code};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp        <= '0;
         sym_count <= '0;
         error_q   <= 1'b0;
         wait_cnt  <= '0;
         child     <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               sp        <= SP_W'(1);
               sym_count <= '0;
               error_q   <= 1'b0;
            end
            S_READ: wait_cnt <= '0;
            S_WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (wait_last) child <= mem_rdata;
            end
            S_EVAL:    if (is_internal && !at_max) sp <= sp + 1'b1;
            S_WRITE:   if (!table_full) sym_count <= sym_count + 1'b1;
            S_ADVANCE: if (top_br) sp <= sp - 1'b1;
            S_ERR:     error_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // Stack contents need no reset: sp alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start) begin
         stk_node[0] <= '0;
         stk_br[0]   <= 1'b0;
      end else if (state == S_EVAL && is_internal && !at_max) begin
         stk_node[push_idx] <= child[SYM_W-1:0];
         stk_br[push_idx]   <= 1'b0;
      end else if (state == S_ADVANCE && !top_br) begin
         stk_br[top_idx] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_huffman_code_gen.sv
// tb/tb_huffman_code_gen.sv - scoreboard bench for huffman_code_gen
module tb_huffman_code_gen;

   localparam int NI = 4;   // 0: default, 1: MAX_LEN=2, 2: MEM_LAT=1, 3: MEM_LAT=4

   typedef struct {
      int addr;
      int len;
      int code;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [8:0]    tree [0:1023];
   logic [NI-1:0] start_v, busy_v, done_v, error_v, rd_v, wr_v;
   logic [8:0]    cnt_v [NI];
   exp_t          exp_q [NI][$];
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   task automatic chk(string name, longint act, longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : inst
      localparam int ML  = (g == 1) ? 2 : 16;
      localparam int LAT = (g == 2) ? 1 : ((g == 3) ? 4 : 2);

      logic            busy, done, error, mem_rd, mem_wr;
      logic [8:0]      sym_count, mem_rdata;
      logic [9:0]      mem_addr;
      logic [5+ML-1:0] mem_wdata;
      logic [9:0]      apipe [LAT];
      logic [LAT-1:0]  vpipe;
      exp_t            e;

      huffman_code_gen #(.MAX_LEN(ML), .MEM_LAT(LAT)) dut (
         .clk(clk), .rst(rst), .start(start_v[g]), .busy(busy), .done(done),
         .error(error), .sym_count(sym_count), .mem_addr(mem_addr),
         .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
         .mem_wdata(mem_wdata)
      );

      assign busy_v[g]  = busy;
      assign done_v[g]  = done;
      assign error_v[g] = error;
      assign rd_v[g]    = mem_rd;
      assign wr_v[g]    = mem_wr;
      assign cnt_v[g]   = sym_count;

      // Memory model: read data visible only in the LAT-th cycle after the read.
      always @(posedge clk) begin
         if (rst) vpipe <= '0;
         else begin
            apipe[0] <= mem_addr;
            vpipe[0] <= mem_rd;
            for (int i = 1; i < LAT; i++) begin
               apipe[i] <= apipe[i-1];
               vpipe[i] <= vpipe[i-1];
            end
         end
      end
      assign mem_rdata = vpipe[LAT-1] ? tree[apipe[LAT-1]] : 9'h1FF;

      // Monitor
      always @(negedge clk) begin
         if (mem_rd && mem_wr) chk("rd_wr_overlap", 1, 0);
         if (mem_wr) begin
            if (exp_q[g].size() == 0) chk("unexpected_write", longint'(mem_addr), -1);
            else begin
               e = exp_q[g].pop_front();
               chk("wr_addr", longint'(mem_addr), e.addr);
               chk("wr_len",  longint'(mem_wdata[5+ML-1:ML]), e.len);
               chk("wr_code", longint'(mem_wdata[ML-1:0]), e.code);
            end
         end
      end
   end

   task automatic node(int n, int b0, int b1);
      tree[256 + 2*n]     = 9'(b0);
      tree[256 + 2*n + 1] = 9'(b1);
   endtask

   task automatic push(int g, int a, int l, int c);
      exp_t e;
      e.addr = a; e.len = l; e.code = c;
      exp_q[g].push_back(e);
   endtask

   task automatic run(int g, int exp_cyc, int exp_err, int exp_cnt);
      int cyc;
      @(negedge clk); start_v[g] = 1'b1;
      @(negedge clk); start_v[g] = 1'b0;
      cyc = 1;
      while (!done_v[g] && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_cycle", cyc, exp_cyc);
      chk("busy_at_done", longint'(busy_v[g]), 1);
      chk("error", longint'(error_v[g]), exp_err);
      chk("sym_count", longint'(cnt_v[g]), exp_cnt);
      chk("queue_drained", exp_q[g].size(), 0);
      @(negedge clk);
      chk("idle_after_done", longint'(busy_v[g]), 0);
   endtask

   task automatic tree_s2();
      node(0, 'h41, 'h101);
      node(1, 'h42, 'h43);
   endtask

   task automatic push_s2(int g);
      push(g, 'h41, 1, 'h0000);
      push(g, 'h42, 2, 'h8000);
      push(g, 'h43, 2, 'hC000);
   endtask

   initial begin
      int cyc, strobes;
      start_v = '0;
      rst = 1'b1;
      for (int i = 0; i < 1024; i++) tree[i] = '0;
      repeat (2) @(negedge clk);

      chk("rst_busy",      longint'(busy_v[0]), 0);
      chk("rst_done",      longint'(done_v[0]), 0);
      chk("rst_error",     longint'(error_v[0]), 0);
      chk("rst_count",     longint'(cnt_v[0]), 0);
      chk("rst_strobes",   longint'({rd_v[0], wr_v[0]}), 0);
      chk("rst_addr",      longint'(inst[0].mem_addr), 0);
      chk("rst_wdata",     longint'(inst[0].mem_wdata), 0);
      rst = 1'b0;

      // Two-leaf tree
      node(0, 'h41, 'h42);
      push(0, 'h41, 1, 'h0000);
      push(0, 'h42, 1, 'h8000);
      run(0, 13, 0, 2);

      // Three-level tree at latencies 2, 1, 4
      tree_s2();
      push_s2(0); run(0, 24, 0, 3);
      push_s2(2); run(2, 20, 0, 3);
      push_s2(3); run(3, 32, 0, 3);

      // Depth overflow with MAX_LEN=2
      node(0, 'h41, 'h101);
      node(1, 'h42, 'h102);
      node(2, 'h43, 'h44);
      push(1, 'h41, 1, 0);
      push(1, 'h42, 2, 2);
      run(1, 21, 1, 2);
      repeat (4) begin
         @(negedge clk);
         chk("error_sticky", longint'(error_v[1]), 1);
         chk("done_low_after_err", longint'(done_v[1]), 0);
      end
      node(0, 'h41, 'h42);
      push(1, 'h41, 1, 0);
      push(1, 'h42, 1, 2);
      run(1, 13, 0, 2);

      // Reset during WAIT of the second read
      tree_s2();
      push_s2(0);
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      repeat (7) @(negedge clk);   // now in cycle 8
      #1 rst = 1'b1;
      #1;
      chk("abort_busy",    longint'(busy_v[0]), 0);
      chk("abort_done",    longint'(done_v[0]), 0);
      chk("abort_error",   longint'(error_v[0]), 0);
      chk("abort_count",   longint'(cnt_v[0]), 0);
      chk("abort_strobes", longint'({rd_v[0], wr_v[0]}), 0);
      chk("abort_pending", exp_q[0].size(), 2);
      exp_q[0].delete();
      strobes = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         strobes += int'(rd_v[0]) + int'(wr_v[0]) + int'(busy_v[0]);
      end
      chk("post_abort_activity", strobes, 0);
      push_s2(0);
      run(0, 24, 0, 3);

      // start held high across a whole run
      node(0, 'h41, 'h42);
      push(0, 'h41, 1, 'h0000); push(0, 'h42, 1, 'h8000);
      push(0, 'h41, 1, 'h0000); push(0, 'h42, 1, 'h8000);
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk);
      cyc = 1;
      while (!done_v[0] && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk("held_done_cycle", cyc, 13);
      @(negedge clk);
      chk("held_idle_gap", longint'(busy_v[0]), 0);
      @(negedge clk);
      chk("held_restart_rd", longint'(rd_v[0]), 1);
      start_v[0] = 1'b0;
      cyc = 1;
      while (!done_v[0] && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk("held_second_done", cyc, 13);
      chk("held_second_count", longint'(cnt_v[0]), 2);
      chk("held_queue_drained", exp_q[0].size(), 0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
